// File: rtl/ciaa_key_arbiter.sv
`default_nettype none
// ciaa_key_arbiter: shares the CIA-A key channel between the PS/2 decoder and a host FIFO,
// sequencing power-up codes, per-byte handshake, ack timeout and $F9 resync with one retry.
module ciaa_key_arbiter #(
   parameter int          FIFO_AW     = 3,
   parameter logic [19:0] ACK_TIMEOUT = 20'd1015000,
   parameter bit          INIT_CODES  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk7_en,
   input  logic [7:0] kbd_dat,
   input  logic       kbd_strobe,
   output logic       kbd_ack,
   input  logic [7:0] host_dat,
   input  logic       host_wr,
   output logic       host_full,
   output logic [7:0] cia_dat,
   output logic       cia_strobe,
   input  logic       cia_ack,
   output logic       busy,
   output logic [7:0] drop_cnt
);

   typedef enum logic [2:0] {
      S_INIT_FD   = 3'd0,
      S_INIT_FE   = 3'd1,
      S_IDLE      = 3'd2,
      S_SEND      = 3'd3,
      S_WAIT_ACK  = 3'd4,
      S_SYNC      = 3'd5,
      S_SYNC_WAIT = 3'd6
   } state_t;

   localparam int             DEPTH     = 1 << FIFO_AW;
   localparam logic [19:0]    TMO_LAST  = ACK_TIMEOUT - 20'd1;
   localparam logic           GNT_KBD   = 1'b0;
   localparam logic           GNT_HOST  = 1'b1;
   localparam logic [FIFO_AW-1:0] PTR_ONE   = {{(FIFO_AW-1){1'b0}}, 1'b1};
   localparam logic [FIFO_AW:0]   CNT_ONE   = {{FIFO_AW{1'b0}}, 1'b1};
   localparam logic [FIFO_AW:0]   CNT_DEPTH = {1'b1, {FIFO_AW{1'b0}}};
   localparam state_t         S_RESET   = INIT_CODES ? S_INIT_FD : S_IDLE;

   state_t             state_q, state_d, ret_q, ret_d;
   logic               init_q, init_d;
   logic               gnt_q, gnt_d;
   logic               last_q, last_d;
   logic               retry_q, retry_d;
   logic               kbd_pend_q, kbd_pend_d;
   logic [7:0]         kbd_buf_q, kbd_buf_d;
   logic [19:0]        timer_q, timer_d;
   logic [7:0]         cia_dat_q, cia_dat_d;
   logic               cia_strobe_q, cia_strobe_d;
   logic               kbd_ack_q, kbd_ack_d;
   logic [7:0]         drop_q, drop_d;
   logic [7:0]         fifo_mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               full_q, full_d;

   logic               fifo_empty, fifo_pop, fifo_push;
   logic               host_drop, kbd_drop, xfer_drop, complete, timeout;
   logic [7:0]         fifo_head;
   logic [1:0]         drop_inc;
   logic [8:0]         drop_sum;

   always_comb begin
      state_d      = state_q;
      ret_d        = ret_q;
      init_d       = init_q;
      gnt_d        = gnt_q;
      last_d       = last_q;
      retry_d      = retry_q;
      kbd_pend_d   = kbd_pend_q;
      kbd_buf_d    = kbd_buf_q;
      timer_d      = timer_q;
      cia_dat_d    = cia_dat_q;
      cia_strobe_d = 1'b0;
      kbd_ack_d    = 1'b0;
      fifo_pop     = 1'b0;
      xfer_drop    = 1'b0;
      complete     = 1'b0;
      fifo_empty   = (count_q == '0);
      fifo_head    = fifo_mem_q[rd_ptr_q];
      timeout      = (timer_q == TMO_LAST);

      case (state_q)
         S_INIT_FD: begin
            cia_dat_d    = 8'hFD;
            cia_strobe_d = 1'b1;
            timer_d      = '0;
            init_d       = 1'b1;
            ret_d        = S_INIT_FE;
            state_d      = S_WAIT_ACK;
         end
         S_INIT_FE: begin
            cia_dat_d    = 8'hFE;
            cia_strobe_d = 1'b1;
            timer_d      = '0;
            init_d       = 1'b1;
            ret_d        = S_IDLE;
            state_d      = S_WAIT_ACK;
         end
         S_IDLE: begin
            // Round-robin only matters when both sides are waiting.
            if (kbd_pend_q && (fifo_empty || last_q == GNT_HOST)) begin
               gnt_d     = GNT_KBD;
               last_d    = GNT_KBD;
               cia_dat_d = kbd_buf_q;
               init_d    = 1'b0;
               state_d   = S_SEND;
            end else if (!fifo_empty) begin
               gnt_d     = GNT_HOST;
               last_d    = GNT_HOST;
               cia_dat_d = fifo_head;
               init_d    = 1'b0;
               state_d   = S_SEND;
            end
         end
         S_SEND: begin
            cia_strobe_d = 1'b1;
            timer_d      = '0;
            state_d      = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            timer_d = timer_q + 20'd1;
            if (cia_ack || timeout) begin
               if (init_q) begin
                  state_d = ret_q;
               end else if (cia_ack || retry_q) begin
                  complete  = 1'b1;
                  xfer_drop = !cia_ack;
               end else begin
                  retry_d = 1'b1;
                  state_d = S_SYNC;
               end
            end
         end
         S_SYNC: begin
            cia_dat_d    = 8'hF9;
            cia_strobe_d = 1'b1;
            timer_d      = '0;
            state_d      = S_SYNC_WAIT;
         end
         S_SYNC_WAIT: begin
            timer_d = timer_q + 20'd1;
            if (cia_ack || timeout) begin
               // The host byte is still at the FIFO head; it is popped only on completion.
               cia_dat_d = (gnt_q == GNT_HOST) ? fifo_head : kbd_buf_q;
               state_d   = S_SEND;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (complete) begin
         retry_d = 1'b0;
         state_d = S_IDLE;
         if (gnt_q == GNT_KBD) begin
            kbd_pend_d = 1'b0;
            kbd_ack_d  = 1'b1;
         end else begin
            fifo_pop = 1'b1;
         end
      end

      kbd_drop = kbd_strobe && kbd_pend_q;
      if (kbd_strobe) begin
         if (kbd_pend_q) begin
            kbd_ack_d = 1'b1;
         end else begin
            kbd_pend_d = 1'b1;
            kbd_buf_d  = kbd_dat;
         end
      end

      fifo_push = host_wr && (!full_q || fifo_pop);
      host_drop = host_wr && full_q && !fifo_pop;
      wr_ptr_d  = fifo_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d  = fifo_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      case ({fifo_push, fifo_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      full_d = (count_d == CNT_DEPTH);

      drop_inc = {1'b0, kbd_drop} + {1'b0, host_drop} + {1'b0, xfer_drop};
      drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};
      drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_RESET;
         ret_q        <= S_IDLE;
         init_q       <= 1'b0;
         gnt_q        <= GNT_KBD;
         last_q       <= GNT_HOST;
         retry_q      <= 1'b0;
         kbd_pend_q   <= 1'b0;
         kbd_buf_q    <= 8'h00;
         timer_q      <= '0;
         cia_dat_q    <= 8'h00;
         cia_strobe_q <= 1'b0;
         kbd_ack_q    <= 1'b0;
         drop_q       <= 8'h00;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         full_q       <= 1'b0;
      end else if (clk7_en) begin
         state_q      <= state_d;
         ret_q        <= ret_d;
         init_q       <= init_d;
         gnt_q        <= gnt_d;
         last_q       <= last_d;
         retry_q      <= retry_d;
         kbd_pend_q   <= kbd_pend_d;
         kbd_buf_q    <= kbd_buf_d;
         timer_q      <= timer_d;
         cia_dat_q    <= cia_dat_d;
         cia_strobe_q <= cia_strobe_d;
         kbd_ack_q    <= kbd_ack_d;
         drop_q       <= drop_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         full_q       <= full_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && clk7_en && fifo_push) begin
         fifo_mem_q[wr_ptr_q] <= host_dat;
      end
   end

   assign kbd_ack    = kbd_ack_q;
   assign host_full  = full_q;
   assign cia_dat    = cia_dat_q;
   assign cia_strobe = cia_strobe_q;
   assign busy       = (state_q != S_IDLE);
   assign drop_cnt   = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_ciaa_key_arbiter.sv
`default_nettype none
// tb_ciaa_key_arbiter: directed vectors for the CIA-A key arbiter with a short ack timeout.
module tb_ciaa_key_arbiter;
   localparam int          T_OUT = 40;
   localparam logic [19:0] ACK_TIMEOUT = 20'd40;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clk7_en = 1'b0;
   logic [7:0] kbd_dat = 8'h00;
   logic       kbd_strobe = 1'b0;
   logic       kbd_ack;
   logic [7:0] host_dat = 8'h00;
   logic       host_wr = 1'b0;
   logic       host_full;
   logic [7:0] cia_dat;
   logic       cia_strobe;
   logic       cia_ack = 1'b0;
   logic       busy;
   logic [7:0] drop_cnt;

   int         errs = 0;
   int         checks = 0;
   int         step_no = 0;
   int         kack_cnt = 0;
   int         kack_timed = 0;
   int         ack_cnt = 0;
   int         ack_delay = 2;
   bit         auto_ack = 1'b0;
   bit         was_ack = 1'b0;
   logic [7:0] log_dat[$];
   int         log_t[$];

   ciaa_key_arbiter #(
      .FIFO_AW     (3),
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .INIT_CODES  (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clk7_en    (clk7_en),
      .kbd_dat    (kbd_dat),
      .kbd_strobe (kbd_strobe),
      .kbd_ack    (kbd_ack),
      .host_dat   (host_dat),
      .host_wr    (host_wr),
      .host_full  (host_full),
      .cia_dat    (cia_dat),
      .cia_strobe (cia_strobe),
      .cia_ack    (cia_ack),
      .busy       (busy),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got no finish, expected finish before 2ms");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One enabled clk followed by one disabled clk; outputs sampled on the falling edge.
   task automatic step();
      @(negedge clk);
      clk7_en = 1'b1;
      @(negedge clk);
      clk7_en = 1'b0;
      step_no++;
      was_ack = cia_ack;
      if (cia_strobe) begin
         log_dat.push_back(cia_dat);
         log_t.push_back(step_no);
      end
      if (kbd_ack) begin
         kack_cnt++;
         if (was_ack) kack_timed++;
      end
      kbd_strobe = 1'b0;
      host_wr    = 1'b0;
      cia_ack    = 1'b0;
      if (cia_strobe) begin
         ack_cnt = ack_delay;
      end else if (ack_cnt > 0) begin
         ack_cnt--;
         if (ack_cnt == 0 && auto_ack) cia_ack = 1'b1;
      end
   endtask

   task automatic clear_log();
      log_dat.delete();
      log_t.delete();
      kack_cnt   = 0;
      kack_timed = 0;
   endtask

   task automatic do_reset(input bit check_vals, input bit run_init);
      @(negedge clk);
      reset = 1'b1;
      kbd_strobe = 1'b0;
      host_wr    = 1'b0;
      cia_ack    = 1'b0;
      repeat (3) @(negedge clk);
      if (check_vals) begin
         chk("rst_cia_dat", cia_dat, 8'h00);
         chk("rst_cia_strobe", cia_strobe, 1'b0);
         chk("rst_kbd_ack", kbd_ack, 1'b0);
         chk("rst_host_full", host_full, 1'b0);
         chk("rst_busy", busy, 1'b1);
         chk("rst_drop_cnt", drop_cnt, 8'h00);
      end
      reset   = 1'b0;
      ack_cnt = 0;
      if (run_init) begin
         auto_ack  = 1'b1;
         ack_delay = 2;
         for (int i = 0; i < 40 && busy; i++) step();
         chk("init_done", busy, 1'b0);
         auto_ack = 1'b0;
      end
      clear_log();
   endtask

   initial begin
      int acks;

      // Power-up codes with acks 10 enables after each strobe.
      do_reset(1'b1, 1'b0);
      auto_ack  = 1'b1;
      ack_delay = 10;
      acks = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (was_ack) acks++;
         if (acks == 2) break;
      end
      chk("init_ack_count", acks, 2);
      chk("init_busy_after_ack2", busy, 1'b0);
      chk("init_n_codes", log_dat.size(), 2);
      if (log_dat.size() == 2) begin
         chk("init_code0", log_dat[0], 8'hFD);
         chk("init_code1", log_dat[1], 8'hFE);
      end
      chk("init_no_kbd_ack", kack_cnt, 0);
      auto_ack = 1'b0;

      // Single PS/2 byte, acked 5 enables after strobe.
      clear_log();
      kbd_dat = 8'h45; kbd_strobe = 1'b1;
      step();
      auto_ack  = 1'b1;
      ack_delay = 5;
      for (int i = 0; i < 30 && kack_cnt == 0; i++) step();
      chk("kbd_n_strobes", log_dat.size(), 1);
      if (log_dat.size() == 1) chk("kbd_dat", log_dat[0], 8'h45);
      chk("kbd_ack_after_ack", kack_timed, 1);
      step();
      chk("kbd_ack_one_pulse", kbd_ack, 1'b0);
      chk("kbd_ack_total", kack_cnt, 1);
      auto_ack = 1'b0;

      // Simultaneous host + PS/2 requests: PS/2 wins first after reset.
      do_reset(1'b0, 1'b1);
      host_dat = 8'h20; host_wr = 1'b1;
      kbd_dat  = 8'h45; kbd_strobe = 1'b1;
      step();
      host_dat = 8'h21; host_wr = 1'b1;
      step();
      auto_ack  = 1'b1;
      ack_delay = 3;
      for (int i = 0; i < 80 && !(log_dat.size() == 3 && !busy); i++) step();
      chk("rr_n_strobes", log_dat.size(), 3);
      if (log_dat.size() == 3) begin
         chk("rr_first", log_dat[0], 8'h45);
         chk("rr_second", log_dat[1], 8'h20);
         chk("rr_third", log_dat[2], 8'h21);
      end
      auto_ack = 1'b0;

      // Timeout -> $F9 resync -> resend -> second timeout drops the byte.
      do_reset(1'b0, 1'b1);
      kbd_dat = 8'h33; kbd_strobe = 1'b1;
      step();
      for (int i = 0; i < T_OUT + 10 && log_dat.size() < 2; i++) step();
      chk("tmo_n_strobes", log_dat.size(), 2);
      if (log_dat.size() == 2) begin
         chk("tmo_sync_code", log_dat[1], 8'hF9);
         chk("tmo_gap", log_t[1] - log_t[0], T_OUT + 1);
      end
      repeat (3) step();
      cia_ack = 1'b1;
      step();
      for (int i = 0; i < 5 && log_dat.size() < 3; i++) step();
      chk("tmo_resend_n", log_dat.size(), 3);
      if (log_dat.size() == 3) chk("tmo_resend_dat", log_dat[2], 8'h33);
      for (int i = 0; i < T_OUT + 10 && kack_cnt == 0; i++) step();
      chk("tmo_drop_cnt", drop_cnt, 8'd1);
      chk("tmo_kbd_ack", kack_cnt, 1);
      chk("tmo_idle", busy, 1'b0);
      chk("tmo_no_extra_strobe", log_dat.size(), 3);

      // Ack on the very cycle the timeout would fire: ack wins.
      kbd_dat = 8'h34; kbd_strobe = 1'b1;
      step();
      for (int i = 0; i < 5 && log_dat.size() < 4; i++) step();
      repeat (T_OUT - 1) step();
      cia_ack = 1'b1;
      step();
      chk("ackwin_kbd_ack", kbd_ack, 1'b1);
      chk("ackwin_drop_cnt", drop_cnt, 8'd1);
      repeat (4) step();
      chk("ackwin_no_sync", log_dat.size(), 4);
      chk("ackwin_idle", busy, 1'b0);

      // Host FIFO fill: full after 8 entries, 9th dropped.
      do_reset(1'b0, 1'b1);
      for (int i = 0; i < 9; i++) begin
         host_dat = 8'h60 + 8'(i);
         host_wr  = 1'b1;
         step();
         if (i == 6) chk("fifo_not_full_7", host_full, 1'b0);
         if (i == 7) chk("fifo_full_8", host_full, 1'b1);
      end
      chk("fifo_drop_9th", drop_cnt, 8'd1);
      cia_ack = 1'b1;
      step();
      chk("fifo_not_full_after_pop", host_full, 1'b0);
      for (int i = 0; i < 10 && log_dat.size() < 2; i++) step();
      chk("fifo_n_strobes", log_dat.size(), 2);
      if (log_dat.size() == 2) begin
         chk("fifo_first", log_dat[0], 8'h60);
         chk("fifo_second", log_dat[1], 8'h61);
      end
      for (int i = 0; i < 400; i++) begin
         host_dat = 8'hA5;
         host_wr  = 1'b1;
         step();
      end
      chk("drop_saturate", drop_cnt, 8'hFF);

      // Mid-operation reset clears everything.
      do_reset(1'b1, 1'b1);
      chk("midrst_drop_cnt", drop_cnt, 8'h00);

      // Second PS/2 byte while one is pending is discarded but acked.
      kbd_dat = 8'h45; kbd_strobe = 1'b1;
      step();
      kbd_dat = 8'h50; kbd_strobe = 1'b1;
      step();
      chk("dup_kbd_ack", kbd_ack, 1'b1);
      chk("dup_drop_cnt", drop_cnt, 8'd1);
      auto_ack  = 1'b1;
      ack_delay = 3;
      for (int i = 0; i < 40 && kack_cnt < 2; i++) step();
      repeat (4) step();
      chk("dup_kbd_ack_total", kack_cnt, 2);
      chk("dup_n_strobes", log_dat.size(), 1);
      if (log_dat.size() == 1) chk("dup_dat", log_dat[0], 8'h45);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ciaa_key_arbiter.md
Name: ciaa_key_arbiter

Overview:
- Sits between the PS/2 keyboard decoder and the CIA-A serial-port key input.
- Shares the single CIA key channel between two requesters:
  - PS/2 decoder: one-cycle strobe, needs a release acknowledge.
  - Host/OSD injection FIFO.
- Sequences the Amiga keyboard protocol: power-up codes, per-byte CIA handshake, ack timeout, and lost-sync ($F9) recovery with one retry.

Parameters:
- FIFO_AW, 3, log2 of host-injection FIFO depth (8 entries).
- ACK_TIMEOUT, 20'd1015000, clk7_en cycles to wait for cia_ack (~143 ms at 7.09 MHz).
- INIT_CODES, 1, when 1, send $FD then $FE after reset before normal traffic.

Ports:
- clk  in  1  bus clock
- reset  in  1  synchronous, active-high reset
- clk7_en  in  1  clock enable; all state advances only when high
- kbd_dat  in  8  PS/2 decoder Amiga raw code (bit7 = key up)
- kbd_strobe  in  1  one-enable-cycle pulse, kbd_dat valid
- kbd_ack  out  1  one-enable-cycle pulse releasing the PS/2 decoder
- host_dat  in  8  injected raw code
- host_wr  in  1  FIFO write, sampled on clk7_en
- host_full  out  1  FIFO full
- cia_dat  out  8  code presented to CIA serial shifter
- cia_strobe  out  1  one-enable-cycle pulse, cia_dat valid
- cia_ack  in  1  CIA handshake, byte consumed
- busy  out  1  high in any state except IDLE
- drop_cnt  out  8  saturating count of dropped bytes

Behaviour:
- Reset:
  - reset is synchronous and active-high, effective on any clk rising edge regardless of clk7_en.
  - Reset values: state = INIT_FD (or IDLE if INIT_CODES = 0), FIFO empty, kbd_pend = 0, retry = 0, timer = 0.
  - Output reset values: cia_dat = 8'h00, cia_strobe = 0, kbd_ack = 0, host_full = 0, busy = 1 (0 if INIT_CODES = 0), drop_cnt = 0.
- Timing: all registers update only on clk7_en. Pulse outputs are high for exactly one clk7_en cycle and low otherwise.
- PS/2 capture:
  - On kbd_strobe with kbd_pend = 0: latch kbd_dat into kbd_buf and set kbd_pend.
  - On kbd_strobe with kbd_pend = 1: discard the new byte, drop_cnt++, and pulse kbd_ack the next cycle so the decoder is not stalled.
- Host FIFO:
  - A write while full is ignored and increments drop_cnt.
  - A write and a pop in the same cycle while full is accepted.
  - host_full is registered.
- drop_cnt saturates at 8'hFF.
- States:
  - INIT_FD: cia_dat = $FD, strobe, go to WAIT_ACK; return target INIT_FE.
  - INIT_FE: same with $FE; return target IDLE.
  - IDLE: grant selection.
    - If only one source is pending, grant it.
    - If both are pending, grant the source opposite to last_grant (round-robin); last_grant resets to HOST, so PS/2 wins first.
    - Load cia_dat and go to SEND. A kbd_strobe arriving in the same cycle is not eligible until the next cycle.
  - SEND: cia_strobe = 1, timer cleared, go to WAIT_ACK.
  - WAIT_ACK: timer++.
    - On cia_ack: complete.
    - On timer == ACK_TIMEOUT-1 with no ack: timeout.
    - If cia_ack and timeout coincide, ack wins.
  - Complete:
    - If the granted source is PS/2: clear kbd_pend and pulse kbd_ack.
    - If the granted source is host: pop FIFO at complete.
    - Clear retry; go to IDLE (or the INIT target).
  - Timeout with retry = 0: set retry, go to SYNC.
  - SYNC: cia_dat = $F9 with strobe, wait for ack/timeout with the same rules. On ack or timeout, reload the original byte and go to SEND.
  - Timeout with retry = 1: drop the byte (drop_cnt++), then perform the complete actions (kbd_ack pulse or FIFO pop).
  - INIT codes are never retried; an INIT timeout advances to the next target.
- Stability: cia_dat is held constant from SEND until the next load. A cia_ack outside WAIT_ACK is ignored.
- Mid-operation reset aborts any transfer with no kbd_ack or cia_strobe emitted in that cycle; FIFO contents are lost.

Test Plan:
- Reset with INIT_CODES = 1, ack each strobe after 10 enables -> cia_dat sequence $FD, $FE; busy drops 1 cycle after the second ack; kbd_ack never pulses.
- kbd_strobe with $45 in IDLE, ack after 5 enables -> exactly one cia_strobe with $45, then one kbd_ack pulse the cycle after ack.
- Host writes $20, $21 and kbd_strobe $45 in the same cycle from IDLE -> order $45, $20 (the $45 grant happens the cycle after the strobe is captured), then $21 after the queue drains.
- No cia_ack for ACK_TIMEOUT enables on $33 -> $F9 sent, ack it -> $33 re-sent. Withhold ack again -> drop_cnt = 1, kbd_ack pulses, state IDLE.
- 9 host writes with no acks -> host_full = 1 after 8 entries (7 once the first pop occurs), the 9th write dropped, drop_cnt = 1.
- Second kbd_strobe $50 while $45 pending -> $50 discarded, drop_cnt++, extra kbd_ack pulse; only $45 reaches cia_dat.
